// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-entry instruction cache controller with a two-state
// miss FSM (IDLE/FETCH), deferred flush during fills and saturating hit/miss counters.
module icache_ctrl #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = 30 - IdxW;

    typedef enum logic {StIdle, StFetch} state_e;

    state_e            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic              flush_pend_q, flush_pend_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]   valid_q;
    logic [TagW-1:0]   tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IdxW-1:0]   req_idx, fill_idx;
    logic [TagW-1:0]   req_tag, fill_tag;
    logic              lookup_hit, fill_we, clear_all;
    logic              unused_addr_lsb;

    assign req_idx  = imemaddr[IdxW+1:2];
    assign req_tag  = imemaddr[31:IdxW+2];
    assign fill_idx = miss_addr_q[IdxW+1:2];
    assign fill_tag = miss_addr_q[31:IdxW+2];
    // Word-aligned addressing: byte offset bits never participate.
    assign unused_addr_lsb = ^imemaddr[1:0];

    assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        fill_we      = 1'b0;
        clear_all    = 1'b0;
        ihit         = 1'b0;
        imemload     = 32'h0;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        unique case (state_q)
            StIdle: begin
                // A live flush or one deferred from the last fill blocks lookup and launch.
                if (flush || flush_pend_q) begin
                    clear_all    = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_idx];
                end else if (imemREN) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (ihit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (fill_we && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            miss_addr_q  <= 32'h0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= 16'h0;
            miss_cnt_q   <= 16'h0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (clear_all) begin
                valid_q <= '0;
            end else if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a cycle-level CPU-view cache model checked every
// negative edge, plus literal expectations from hand-worked scenarios.
module tb_icache_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic        flush = 1'b0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    icache_ctrl #(.SETS(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .flush    (flush),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a cache of 16 words seen from outside; "busy" while a miss is outstanding.
    bit        m_busy;
    bit [31:0] m_addr;
    bit        m_pend;
    bit        m_v [16];
    bit [25:0] m_t [16];
    bit [31:0] m_d [16];
    int        m_hits, m_fills;

    function automatic bit m_hit_now();
        return !m_busy && imemREN && !flush && !m_pend && m_v[imemaddr[5:2]]
               && (m_t[imemaddr[5:2]] == imemaddr[31:6]);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy  <= 1'b0;
            m_addr  <= 32'h0;
            m_pend  <= 1'b0;
            m_hits  <= 0;
            m_fills <= 0;
            for (int i = 0; i < 16; i++) begin
                m_v[i] <= 1'b0;
                m_t[i] <= '0;
                m_d[i] <= '0;
            end
        end else if (m_busy) begin
            if (flush) m_pend <= 1'b1;
            if (!iwait) begin
                m_v[m_addr[5:2]] <= 1'b1;
                m_t[m_addr[5:2]] <= m_addr[31:6];
                m_d[m_addr[5:2]] <= iload;
                m_fills <= (m_fills < 65535) ? m_fills + 1 : m_fills;
                m_busy <= 1'b0;
            end
        end else if (flush || m_pend) begin
            for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
            m_pend <= 1'b0;
        end else if (m_hit_now()) begin
            m_hits <= (m_hits < 65535) ? m_hits + 1 : m_hits;
        end else if (imemREN) begin
            m_addr <= {imemaddr[31:2], 2'b00};
            m_busy <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        logic eh;
        eh = m_hit_now();
        chk("ihit", 32'(ihit), 32'(eh));
        chk("imemload", imemload, eh ? m_d[imemaddr[5:2]] : 32'h0);
        chk("iREN", 32'(iREN), 32'(m_busy));
        chk("iaddr", iaddr, m_busy ? m_addr : 32'h0);
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_fills));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch a miss on addr, hold iwait for nwait FETCH cycles, then return data.
    task automatic fill(input logic [31:0] addr, input int nwait, input logic [31:0] data,
                        output int fetch_cycles, output logic launch_hit);
        imemaddr = addr;
        imemREN  = 1'b1;
        iwait    = 1'b1;
        #1;
        launch_hit = ihit;
        tick();
        fetch_cycles = 0;
        repeat (nwait) begin
            if (iREN && iaddr == {addr[31:2], 2'b00}) fetch_cycles++;
            tick();
        end
        iwait = 1'b0;
        iload = data;
        #1;
        if (iREN && iaddr == {addr[31:2], 2'b00}) fetch_cycles++;
        tick();
        iwait = 1'b1;
    endtask

    initial begin
        int   fc;
        logic lh;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk("reset_ihit", 32'(ihit), 32'h0);
        chk("reset_iREN", 32'(iREN), 32'h0);
        chk("reset_iaddr", iaddr, 32'h0);
        chk("reset_hit_cnt", 32'(hit_cnt), 32'h0);
        chk("reset_miss_cnt", 32'(miss_cnt), 32'h0);
        tick();

        // Cold miss with three wait cycles, then five consecutive hits.
        fill(32'h0000_0044, 3, 32'h2001_0005, fc, lh);
        chk("cold_launch_hit", 32'(lh), 32'h0);
        chk("cold_fetch_cycles", 32'(fc), 32'd4);
        chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hits_ihit", 32'(ihit), 32'h1);
            chk("hits_imemload", imemload, 32'h2001_0005);
            chk("hits_iREN", 32'(iREN), 32'h0);
            tick();
        end
        chk("hits_hit_cnt", 32'(hit_cnt), 32'd5);
        imemREN = 1'b0;
        tick();

        // Conflict on index 1: 0x84 evicts 0x44, then 0x44 misses again.
        fill(32'h0000_0084, 1, 32'hDEAD_0084, fc, lh);
        chk("conflict_launch_hit", 32'(lh), 32'h0);
        chk("conflict_ihit", 32'(ihit), 32'h1);
        chk("conflict_load", imemload, 32'hDEAD_0084);
        fill(32'h0000_0044, 0, 32'h2001_0005, fc, lh);
        chk("conflict_refetch_hit", 32'(lh), 32'h0);
        chk("conflict_miss_cnt", 32'(miss_cnt), 32'd3);
        imemREN = 1'b0;
        tick();

        // Flush pulse while a fill is outstanding: filled line is also invalidated.
        imemaddr = 32'h10;
        imemREN  = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        iwait = 1'b0;
        iload = 32'h1111_0010;
        tick();
        iwait = 1'b1;
        chk("fflush_pend_ihit", 32'(ihit), 32'h0);
        tick();
        chk("fflush_rereq_ihit", 32'(ihit), 32'h0);
        tick();
        chk("fflush_rereq_iREN", 32'(iREN), 32'h1);
        iwait = 1'b0;
        tick();
        iwait = 1'b1;
        chk("fflush_refill_ihit", 32'(ihit), 32'h1);
        chk("fflush_refill_load", imemload, 32'h1111_0010);

        // Flush in IDLE on a hit, then flush coinciding with the filling edge.
        flush = 1'b1;
        #1;
        chk("iflush_ihit", 32'(ihit), 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("iflush_after_ihit", 32'(ihit), 32'h0);
        tick();
        iwait = 1'b0;
        iload = 32'h3333_0010;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        iwait = 1'b1;
        chk("edge_flush_pend_ihit", 32'(ihit), 32'h0);
        imemREN = 1'b0;
        tick();

        // Address moves mid-fetch: latched 0x20 is filled, 0x30 is not.
        imemaddr = 32'h20;
        imemREN  = 1'b1;
        tick();
        imemaddr = 32'h30;
        #1;
        chk("midaddr_iaddr0", iaddr, 32'h20);
        tick();
        imemREN = 1'b0;
        #1;
        chk("midaddr_iaddr1", iaddr, 32'h20);
        tick();
        iwait = 1'b0;
        iload = 32'h2222_0020;
        tick();
        iwait = 1'b1;
        imemaddr = 32'h20;
        imemREN  = 1'b1;
        #1;
        chk("midaddr_hit20", 32'(ihit), 32'h1);
        chk("midaddr_load20", imemload, 32'h2222_0020);
        imemaddr = 32'h30;
        #1;
        chk("midaddr_miss30", 32'(ihit), 32'h0);
        imemREN = 1'b0;
        tick();

        // Reset mid-fetch abandons the fill.
        imemaddr = 32'h8;
        imemREN  = 1'b1;
        tick();
        RST = 1'b1;
        #1;
        chk("rstfetch_iREN", 32'(iREN), 32'h0);
        chk("rstfetch_hit_cnt", 32'(hit_cnt), 32'h0);
        chk("rstfetch_miss_cnt", 32'(miss_cnt), 32'h0);
        tick();
        RST = 1'b0;
        #1;
        chk("rstfetch_first_miss", 32'(ihit), 32'h0);

        // Hit-counter saturation.
        fill(32'h8, 0, 32'h4444_0008, fc, lh);
        repeat (65540) tick();
        chk("sat_hit_cnt", 32'(hit_cnt), 32'h0000_FFFF);
        chk("sat_miss_cnt", 32'(miss_cnt), 32'd1);
        imemREN = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 16, meaning number of direct-mapped one-word entries (fixed power of two; index width 4).
REQ-002 SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-004 SHALL have port imemREN  input  1  CPU instruction read request.
REQ-005 SHALL have port imemaddr  input  32  CPU word address; tag=[31:6] (26b), index=[5:2], [1:0] ignored.
REQ-006 SHALL have port ihit  output  1  requested word valid on imemload this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word to CPU.
REQ-008 SHALL have port iREN  output  1  memory read request.
REQ-009 SHALL have port iaddr  output  32  memory read address.
REQ-010 SHALL have port iwait  input  1  memory busy; iwait=0 while iREN=1 means iload valid this cycle.
REQ-011 SHALL have port iload  input  32  memory read data.
REQ-012 SHALL have port flush  input  1  single-cycle pulse: invalidate all entries.
REQ-013 SHALL have port hit_cnt  output  16  saturating count of hit cycles.
REQ-014 SHALL have port miss_cnt  output  16  saturating count of completed fills.

Function
REQ-015 SHALL hold SETS entries, each {data 32b, tag 26b, valid 1b}, written only by this controller's fill strobe.
REQ-016 SHALL implement FSM states IDLE and FETCH.
REQ-017 IDLE: hit = imemREN & valid[index] & (tag[index]==imemaddr[31:6]), combinational; ihit=hit, imemload=data[index] when hit, else imemload=32'h0.
REQ-018 IDLE: imemREN & !hit & !flush SHALL latch imemaddr into miss_addr (bits [1:0] forced 0) and go to FETCH next cycle.
REQ-019 FETCH: iREN=1, iaddr=miss_addr every cycle; ihit=0, imemload=32'h0 regardless of imemREN/imemaddr.
REQ-020 FETCH with iwait=0: entry[miss_addr index] <= {iload, miss_addr tag, valid=1}, miss_cnt increments, return to IDLE; ihit asserts earliest on following cycle (re-lookup).
REQ-021 FETCH with iwait=1: remain in FETCH, no entry change; no timeout.
REQ-022 iREN=0 and iaddr=32'h0 in IDLE.
REQ-023 Changes to imemaddr or imemREN deassertion during FETCH SHALL NOT abort the fill; the latched address is filled.
REQ-024 flush in IDLE: all valid bits cleared at next edge; ihit forced 0 that cycle; no miss launched that cycle.
REQ-025 flush in FETCH: set flush_pend; fill still completes; on the IDLE return edge... flush_pend applies in the first IDLE cycle (ihit forced 0, all valid cleared at its end, flush_pend cleared), so the filled entry is also invalidated.
REQ-026 flush coinciding with the filling edge (iwait=0 in FETCH) SHALL behave as REQ-025.
REQ-027 hit_cnt SHALL increment each cycle ihit=1; hit_cnt and miss_cnt saturate at 16'hFFFF, never wrap; neither cleared by flush.
REQ-028 Fill to an index holding a valid entry with a different tag SHALL overwrite it (no victim handling).

Reset
REQ-029 RST=1 SHALL asynchronously force state=IDLE, all valid=0, all data/tag=0, miss_addr=0, flush_pend=0, hit_cnt=0, miss_cnt=0; outputs ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-030 RST asserted during FETCH SHALL abandon the fill with no entry written; first request after release SHALL miss.

Verification
REQ-031 Cold miss: after reset, imemREN=1, imemaddr=32'h0000_0044, memory iwait=1 for 3 cycles then iload=32'h2001_0005 -> iREN/iaddr=32'h44 for 4 cycles, ihit=1 with imemload=32'h2001_0005 on cycle after fill, miss_cnt=1.
REQ-032 Conflict: fill 32'h44 then request 32'h84 (same index 1, different tag) -> miss, fetch 32'h84, entry overwritten; re-request 32'h44 misses again, miss_cnt=3.
REQ-033 Hits: 5 consecutive cycles requesting cached 32'h44 -> ihit=1 each cycle, iREN=0 throughout, hit_cnt +5.
REQ-034 Flush during FETCH: miss on 32'h10, pulse flush with iwait=1 -> fill completes, next IDLE cycle ihit=0, following request to 32'h10 misses.
REQ-035 Address change mid-fetch: miss on 32'h20, change imemaddr to 32'h30 while iwait=1 -> iaddr stays 32'h20, entry index 8 filled, then 32'h30 misses.
REQ-036 Reset mid-fetch and counter saturation: RST pulse in FETCH -> iREN=0 immediately, counters 0; forcing 65540 hit cycles -> hit_cnt=16'hFFFF.
